// File: rtl/mult32x32_seq.sv
// Operand FIFO, job sequencer and result-holding stage in front of a 32x32 iterative multiplier.
// Define MULT_SEQ_SIGNED_EN for two's-complement operands (sign-magnitude around an unsigned multiplier).
module mult32x32_seq #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_a,
   input  logic [31:0]                in_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [63:0]                out_product,
   output logic                       mult_start,
   output logic [31:0]                mult_a,
   output logic [31:0]                mult_b,
   input  logic                       mult_busy,
   input  logic [63:0]                mult_product,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [63:0]        mem_q [DEPTH];
   logic [63:0]        mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               in_ready_q, in_ready_d;
   logic [31:0]        op_a_q, op_a_d;
   logic [31:0]        op_b_q, op_b_d;
   logic               mult_start_q, mult_start_d;
   logic               out_valid_q, out_valid_d;
   logic [63:0]        product_q, product_d;
   logic               push_s;
   logic               pop_s;
   logic [63:0]        head_s;
`ifdef MULT_SEQ_SIGNED_EN
   logic               sign_q, sign_d;

   function automatic logic [31:0] magnitude32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [63:0] negate64(input logic [63:0] v);
      return ~v + 64'd1;
   endfunction
`endif

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_product = product_q;
   assign mult_start  = mult_start_q;
   assign mult_a      = op_a_q;
   assign mult_b      = op_b_q;
   assign fifo_count  = count_q;

   assign push_s = in_valid & in_ready_q;
   assign head_s = mem_q[rd_ptr_q];

   // Sequencer: next state, pop decision, operand load and result capture.
   always_comb begin
      state_d     = state_q;
      pop_s       = 1'b0;
      out_valid_d = out_valid_q;
      product_d   = product_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
`ifdef MULT_SEQ_SIGNED_EN
      sign_d      = sign_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (count_q != CNT_W'(0)) begin
               pop_s   = 1'b1;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (!mult_busy) begin
`ifdef MULT_SEQ_SIGNED_EN
               product_d = sign_q ? negate64(mult_product) : mult_product;
`else
               product_d = mult_product;
`endif
               out_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (count_q != CNT_W'(0)) begin
                  pop_s   = 1'b1;
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase

      if (pop_s) begin
`ifdef MULT_SEQ_SIGNED_EN
         op_a_d = magnitude32(head_s[63:32]);
         op_b_d = magnitude32(head_s[31:0]);
         sign_d = head_s[63] ^ head_s[31];
`else
         op_a_d = head_s[63:32];
         op_b_d = head_s[31:0];
`endif
      end else begin
         op_a_d = op_a_q;
         op_b_d = op_b_q;
      end

      mult_start_d = (state_d == ST_ISSUE);
   end

   // FIFO storage, pointers and occupancy; a full FIFO refuses pushes even while popping.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = {in_a, in_b};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      in_ready_d = (count_d != CNT_W'(DEPTH));
   end

   // State register; reset discards the queue and any in-flight job.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         in_ready_q   <= 1'b0;
         op_a_q       <= 32'd0;
         op_b_q       <= 32'd0;
         mult_start_q <= 1'b0;
         out_valid_q  <= 1'b0;
         product_q    <= 64'd0;
`ifdef MULT_SEQ_SIGNED_EN
         sign_q       <= 1'b0;
`endif
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 64'd0;
         end
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         in_ready_q   <= in_ready_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         mult_start_q <= mult_start_d;
         out_valid_q  <= out_valid_d;
         product_q    <= product_d;
`ifdef MULT_SEQ_SIGNED_EN
         sign_q       <= sign_d;
`endif
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_mult32x32_seq.sv
// Scoreboard bench for mult32x32_seq with a behavioural iterative multiplier (fixed busy time).
module tb_mult32x32_seq;

   localparam int DEPTH = 4;
   localparam int BUSY  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_product;
   logic        mult_start;
   logic [31:0] mult_a;
   logic [31:0] mult_b;
   logic        mult_busy;
   logic [63:0] mult_product;
   logic [$clog2(DEPTH):0] fifo_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] sb [$];

   mult32x32_seq #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
      .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
      .mult_busy(mult_busy), .mult_product(mult_product),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural multiplier: busy for BUSY cycles after start, product undefined-looking while busy.
   int          m_cnt;
   logic [63:0] m_pend;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mult_busy    <= 1'b0;
         mult_product <= 64'd0;
         m_cnt        <= 0;
         m_pend       <= 64'd0;
      end else if (mult_start) begin
         m_pend       <= {32'd0, mult_a} * {32'd0, mult_b};
         m_cnt        <= BUSY;
         mult_busy    <= 1'b1;
         mult_product <= 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (m_cnt > 1) begin
         m_cnt <= m_cnt - 1;
      end else if (m_cnt == 1) begin
         m_cnt        <= 0;
         mult_busy    <= 1'b0;
         mult_product <= m_pend;
      end
   end

   // Monitor: compare each accepted result with the scoreboard head; check hold stability.
   logic        held_prev = 1'b0;
   logic [63:0] prod_prev = 64'd0;
   always @(negedge clk) begin
      if (reset) begin
         if (held_prev) begin
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_product", out_product, prod_prev);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", out_product, 64'hFFFF_FFFF_FFFF_FFFF ^ out_product);
            end else begin
               check("product", out_product, sb.pop_front());
            end
         end
         held_prev = out_valid && !out_ready;
         prod_prev = out_product;
      end else begin
         held_prev = 1'b0;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      in_valid = 1'b1; in_a = a; in_b = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(exp);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("push_timeout", 64'd0, 64'd1);
   endtask

   task automatic try_push(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                           output bit acc);
      in_valid = 1'b1; in_a = a; in_b = b;
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back(exp);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !out_valid) done = 1'b1;
      end
      if (!done) check("drain_timeout", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   logic [63:0] exp_ff, exp_fe, exp_80_1;
   int          cyc;
   int          acc_cnt;
   bit          acc;

   initial begin
`ifdef MULT_SEQ_SIGNED_EN
      exp_ff   = 64'h0000_0000_0000_0001;
      exp_fe   = 64'hFFFF_FFFF_FFFF_FFFA;
      exp_80_1 = 64'hFFFF_FFFF_8000_0000;
`else
      exp_ff   = 64'hFFFF_FFFE_0000_0001;
      exp_fe   = 64'h0000_0002_FFFF_FFFA;
      exp_80_1 = 64'h0000_0000_8000_0000;
`endif
      reset = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("init_in_ready", {63'd0, in_ready}, 64'd1);
      check("init_fifo_count", 64'(fifo_count), 64'd0);
      check("init_out_product", out_product, 64'd0);
      check("init_mult_ab", {mult_a, mult_b}, 64'd0);
      check("init_mult_start", {63'd0, mult_start}, 64'd0);
      @(posedge clk); #1;

      // Single job 3 x 5 with latency and one-cycle out_valid
      out_ready = 1'b1;
      push(32'd3, 32'd5, 64'h0000_0000_0000_000F);
      cyc = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check("lat_count1", 64'(fifo_count), 64'd1);
         if (cyc == 2) begin
            check("lat_start", {63'd0, mult_start}, 64'd1);
            check("lat_ops", {mult_a, mult_b}, {32'd3, 32'd5});
         end
         if (out_valid) break;
      end
      check("lat_cycles", 64'(cyc), 64'(3 + BUSY + 1));
      @(negedge clk);
      check("single_valid_drop", {63'd0, out_valid}, 64'd0);
      check("single_count0", 64'(fifo_count), 64'd0);
      @(posedge clk); #1;

      // Sign-sensitive and boundary vectors
      push(32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_ff);
      push(32'hFFFF_FFFE, 32'h0000_0003, exp_fe);
      push(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      push(32'h8000_0000, 32'h0000_0001, exp_80_1);
      drain();

      // Fill with out_ready low: one job in HOLD, DEPTH queued, last attempt refused
      out_ready = 1'b0;
      acc_cnt = 0;
      try_push(32'd1, 32'd2, 64'd2, acc);    acc_cnt += int'(acc);
      try_push(32'd3, 32'd4, 64'd12, acc);   acc_cnt += int'(acc);
      try_push(32'd5, 32'd6, 64'd30, acc);   acc_cnt += int'(acc);
      try_push(32'd7, 32'd8, 64'd56, acc);   acc_cnt += int'(acc);
      try_push(32'd9, 32'd10, 64'd90, acc);  acc_cnt += int'(acc);
      try_push(32'd11, 32'd12, 64'd132, acc); acc_cnt += int'(acc);
      check("full_accepted", 64'(acc_cnt), 64'(DEPTH + 1));
      repeat (10) @(negedge clk);
      check("full_count", 64'(fifo_count), 64'(DEPTH));
      check("full_in_ready", {63'd0, in_ready}, 64'd0);
      check("full_hold_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain();
      check("full_drained", 64'(fifo_count), 64'd0);

      // Reset mid-WAIT with two jobs queued
      push(32'd100, 32'd3, 64'd300);
      push(32'd200, 32'd3, 64'd600);
      push(32'd300, 32'd3, 64'd900);
      @(negedge clk);
      check("pre_rst_count", 64'(fifo_count), 64'd2);
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      @(negedge clk);
      check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_count", 64'(fifo_count), 64'd0);
      check("mid_rst_start", {63'd0, mult_start}, 64'd0);
      check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      push(32'd7, 32'd6, 64'h0000_0000_0000_002A);
      drain();

      // Simultaneous push and pop at fifo_count == 1
      out_ready = 1'b0;
      push(32'h10, 32'h10, 64'h100);
      push(32'h20, 32'h3, 64'h60);
      cyc = 0;
      for (int i = 0; i < 50 && !out_valid; i++) begin
         @(negedge clk);
         cyc++;
      end
      check("pp_hold_reached", {63'd0, out_valid}, 64'd1);
      check("pp_count_before", 64'(fifo_count), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 32'h1234; in_b = 32'h10; out_ready = 1'b1;
      @(negedge clk);
      check("pp_in_ready", {63'd0, in_ready}, 64'd1);
      sb.push_back(64'h12340);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("pp_count_after", 64'(fifo_count), 64'd1);
      @(posedge clk); #1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

endmodule

// File: doc/mult32x32_seq.md
# mult32x32_seq

Operand-queue and result-holding stage placed in front of the 32x32 iterative multiplier. Accepts operand pairs over a valid/ready stream into a small FIFO. Issues one start per job to the multiplier and waits for it to finish. Presents each 64-bit product on a valid/ready output stream.

## Interface
- DEPTH, 4, operand FIFO entries; power of two, ≥2
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  FIFO can accept a pair
- in_a  in  32  operand a
- in_b  in  32  operand b
- out_valid  out  1  out_product holds a finished result
- out_ready  in  1  consumer takes the result
- out_product  out  64  result
- mult_start  out  1  one-cycle start pulse to the multiplier
- mult_a  out  32  operand a to the multiplier
- mult_b  out  32  operand b to the multiplier
- mult_busy  in  1  multiplier busy
- mult_product  in  64  multiplier product
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries

## Operation
- Multiplier contract:
  - mult_start is sampled high for one cycle.
  - mult_busy is high from the next cycle until the product is final.
  - mult_product is valid in the first cycle mult_busy is low after that.
  - mult_a/mult_b are held stable from ISSUE through WAIT.
- FIFO behaviour:
  - Push when in_valid & in_ready. A push writes the entry at wr_ptr.
  - in_ready = (fifo_count != DEPTH), derived from registered count.
  - Pop only when the FSM loads a job. A pop reads the entry at rd_ptr.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
  - There is no bypass: a full FIFO refuses a push even in a cycle that pops.
- FSM states:
  - IDLE: if fifo_count != 0, pop head into op registers → ISSUE.
  - ISSUE: mult_start=1 → WAIT.
  - WAIT: when mult_busy==0, capture result into out_product, set out_valid → HOLD.
  - HOLD: out_valid=1. On out_ready, clear out_valid (unless immediately reloaded). If the FIFO is non-empty, pop and go to ISSUE; otherwise go to IDLE.
- Only one job is in flight at a time. out_product is held stable while out_valid=1 and out_ready=0.
- Reset asserted at any time:
  - FIFO emptied, FSM → IDLE.
  - All outputs 0: in_ready=0 only while reset is asserted, then 1.
  - Any in-flight job is discarded.

## Timing
- Reset values: in_ready 1 (after deassertion), out_valid 0, out_product 0, mult_start 0, mult_a/mult_b 0, fifo_count 0.
- Push into an empty FIFO with the FSM in IDLE at cycle 0:
  - cycle 1: pop
  - cycle 2: ISSUE
  - cycle 3 onward: WAIT
  - out_valid rises the cycle after the first sample of mult_busy==0.
- Overhead is 3 cycles plus the multiplier's busy time plus 1.
- Back-to-back jobs: out_ready in HOLD with a non-empty FIFO reaches ISSUE in the next cycle. No IDLE cycle is inserted.
- mult_busy low on the first WAIT cycle is a contract violation. The sequencer captures anyway.

## Configuration
- MULT_SEQ_SIGNED_EN defined:
  - in_a/in_b are two's complement.
  - The op registers hold magnitudes; |−2^31| = 0x80000000 unsigned.
  - A sign flag is set to in_a[31]^in_b[31].
  - The captured product is negated (two's complement, 64-bit) when the flag is set.
- Undefined: operands pass through unchanged, with unsigned semantics. The sign logic is absent.

## Test plan
- Single job 3 × 5, out_ready=1 → out_product 0x000000000000000F, out_valid for one cycle, fifo_count returns to 0.
- 0xFFFFFFFF × 0xFFFFFFFF:
  - unsigned build → 0xFFFFFFFE00000001
  - signed build → 0x0000000000000001
- 0xFFFFFFFE × 0x00000003:
  - unsigned build → 0x00000002FFFFFFFA
  - signed build → 0xFFFFFFFFFFFFFFFA
- out_ready=0, DEPTH+2 push attempts with distinct operands:
  - fifo_count reaches DEPTH (one job held in HOLD); in_ready drops.
  - The extra pair is not accepted.
  - After releasing out_ready, results emerge in push order with no losses.
- Reset asserted mid-WAIT with 2 queued jobs → out_valid 0, fifo_count 0, mult_start 0. After release, a new job 7 × 6 → 0x000000000000002A.
- Simultaneous push and pop at fifo_count=1 → fifo_count stays 1; both operands are processed in order.
